// File: rtl/sdc_regs_pkg.sv
// Register map, event/response encodings and sequencer state type shared by
// the SD command sequencer and its Wishbone access engine.
package sdc_regs_pkg;

  localparam logic [7:0] ADDR_ARGUMENT         = 8'h00;
  localparam logic [7:0] ADDR_COMMAND          = 8'h04;
  localparam logic [7:0] ADDR_RESPONSE_0       = 8'h08;
  localparam logic [7:0] ADDR_RESPONSE_1       = 8'h0C;
  localparam logic [7:0] ADDR_RESPONSE_2       = 8'h10;
  localparam logic [7:0] ADDR_RESPONSE_3       = 8'h14;
  localparam logic [7:0] ADDR_CMD_EVENT_STATUS = 8'h34;

  localparam int unsigned EV_COMPLETE = 0;
  localparam int unsigned EV_ERROR    = 1;
  localparam int unsigned EV_TIMEOUT  = 2;
  localparam int unsigned EV_CRC      = 3;
  localparam int unsigned EV_INDEX    = 4;

  localparam int unsigned RSP_PRESENT = 0;
  localparam int unsigned RSP_LONG    = 1;
  localparam int unsigned RSP_CRC     = 2;
  localparam int unsigned RSP_BUSY    = 3;

  typedef enum logic [1:0] {
    XFER_NONE  = 2'b00,
    XFER_READ  = 2'b01,
    XFER_WRITE = 2'b10
  } xfer_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ARG,
    ST_WR_CMD,
    ST_POLL,
    ST_GAP,
    ST_RSP,
    ST_CLR,
    ST_DONE
  } seq_state_t;

  function automatic logic [31:0] cmd_word(input logic [5:0] opcode,
                                           input logic [1:0] xfer,
                                           input logic [3:0] rsp_type);
    return {19'b0, opcode, 1'b0, xfer, rsp_type};
  endfunction

endpackage

// File: rtl/sdc_wb_access.sv
// Single-access Wishbone master: latches one request on start, holds the bus
// until ack, then pulses done; cyc is always low for a cycle after each ack.
module sdc_wb_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        we,
  input  logic [7:0]  adr,
  input  logic [31:0] dat,
  output logic        done,
  output logic [31:0] rdata,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      if (wb_cyc_o) begin
        if (wb_ack_i) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          done     <= 1'b1;
          if (!wb_we_o) rdata <= wb_dat_i;
        end
      end else if (start) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= we;
        wb_adr_o <= adr;
        wb_dat_o <= dat;
      end
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one SD command through the sdc_controller register port:
// argument, command, status poll, response readout, status clear.
module sd_cmd_sequencer
  import sdc_regs_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned POLL_GAP   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_opcode,
  input  logic [31:0]  req_arg,
  input  logic [3:0]   req_rsp_type,
  input  logic [1:0]   req_xfer,
  output logic         done_valid,
  input  logic         done_ready,
  output logic         done_ok,
  output logic         done_timeout,
  output logic [4:0]   done_event,
  output logic [127:0] done_rsp,
  output logic         busy,
  output logic [7:0]   wb_adr_o,
  output logic [31:0]  wb_dat_o,
  input  logic [31:0]  wb_dat_i,
  output logic [3:0]   wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  input  logic         wb_ack_i
);

  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

  seq_state_t     state;
  logic [5:0]     op_q;
  logic [31:0]    arg_q;
  logic [3:0]     rsp_q;
  logic [1:0]     xfer_q;
  logic [PW-1:0]  poll_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [1:0]     rsp_idx;

  logic           acc_start;
  logic           acc_pend;
  logic           acc_done;
  logic [31:0]    acc_rdata;
  logic           acc_state;
  logic           acc_we;
  logic [7:0]     acc_adr;
  logic [31:0]    acc_dat;
  logic           ev_none;
  logic           ev_ok;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign done_valid = (state == ST_DONE);
  assign wb_sel_o   = 4'hF;

  assign ev_none = (acc_rdata[EV_INDEX:EV_COMPLETE] == '0);
  assign ev_ok   = acc_rdata[EV_COMPLETE] && (acc_rdata[EV_INDEX:EV_ERROR] == '0);

  // Each bus-owning state decodes its own access; the engine latches it on start.
  always_comb begin
    acc_state = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = '0;
    acc_dat   = '0;
    unique case (state)
      ST_WR_ARG: begin acc_state = 1'b1; acc_we = 1'b1; acc_adr = ADDR_ARGUMENT; acc_dat = arg_q; end
      ST_WR_CMD: begin
        acc_state = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_COMMAND;
        acc_dat   = cmd_word(op_q, xfer_q, rsp_q);
      end
      ST_POLL:   begin acc_state = 1'b1; acc_adr = ADDR_CMD_EVENT_STATUS; end
      ST_RSP:    begin acc_state = 1'b1; acc_adr = ADDR_RESPONSE_0 + {4'b0, rsp_idx, 2'b00}; end
      ST_CLR:    begin acc_state = 1'b1; acc_we = 1'b1; acc_adr = ADDR_CMD_EVENT_STATUS; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      arg_q        <= '0;
      rsp_q        <= '0;
      xfer_q       <= '0;
      poll_cnt     <= '0;
      gap_cnt      <= '0;
      rsp_idx      <= '0;
      acc_start    <= 1'b0;
      acc_pend     <= 1'b0;
      done_ok      <= 1'b0;
      done_timeout <= 1'b0;
      done_event   <= '0;
      done_rsp     <= '0;
    end else begin
      acc_start <= 1'b0;
      if (acc_state && !acc_pend) begin
        acc_start <= 1'b1;
        acc_pend  <= 1'b1;
      end
      if (acc_done) acc_pend <= 1'b0;

      case (state)
        ST_IDLE: if (req_valid) begin
          op_q         <= req_opcode;
          arg_q        <= req_arg;
          rsp_q        <= req_rsp_type;
          xfer_q       <= req_xfer;
          poll_cnt     <= '0;
          done_ok      <= 1'b0;
          done_timeout <= 1'b0;
          done_event   <= '0;
          done_rsp     <= '0;
          state        <= ST_WR_ARG;
        end
        ST_WR_ARG: if (acc_done) state <= ST_WR_CMD;
        ST_WR_CMD: if (acc_done) state <= ST_POLL;
        ST_POLL: if (acc_done) begin
          poll_cnt <= poll_cnt + 1'b1;
          if (ev_none) begin
            if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
              done_timeout <= 1'b1;
              state        <= ST_CLR;
            end else begin
              gap_cnt <= GW'(POLL_GAP);
              state   <= ST_GAP;
            end
          end else begin
            done_event <= acc_rdata[EV_INDEX:EV_COMPLETE];
            done_ok    <= ev_ok;
            if (ev_ok && rsp_q[RSP_PRESENT]) begin
              rsp_idx <= '0;
              state   <= ST_RSP;
            end else begin
              state <= ST_CLR;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_POLL;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        ST_RSP: if (acc_done) begin
          done_rsp[{rsp_idx, 5'd0} +: 32] <= acc_rdata;
          if (!rsp_q[RSP_LONG] || rsp_idx == 2'd3) state <= ST_CLR;
          else                                     rsp_idx <= rsp_idx + 1'b1;
        end
        ST_CLR:  if (acc_done) state <= ST_DONE;
        ST_DONE: if (done_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sdc_wb_access u_access (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (acc_start),
    .we       (acc_we),
    .adr      (acc_adr),
    .dat      (acc_dat),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

endmodule
